// File: rtl/viterbi_pkg.sv
// Trellis constants and helpers shared by the Viterbi decoder and its ACS units.
// K=3 uses G0=111/G1=101, K=4 uses G0=1111/G1=1101; generator MSB taps the newest input bit.
package viterbi_pkg;
    localparam int MAX_STATES = 8;
    localparam logic [2:0] G0_K3 = 3'b111;
    localparam logic [2:0] G1_K3 = 3'b101;
    localparam logic [3:0] G0_K4 = 4'b1111;
    localparam logic [3:0] G1_K4 = 4'b1101;

    function automatic int num_states(input logic k4);
        return k4 ? 8 : 4;
    endfunction

    // Encoder output on the branch into state nxt whose dropped (oldest) bit was x.
    function automatic logic [1:0] branch_out(input logic k4, input logic [2:0] nxt, input logic x);
        logic [3:0] r4;
        logic [2:0] r3;
        r4 = {nxt, x};
        r3 = {nxt[1:0], x};
        if (k4) branch_out = {^(r4 & G0_K4), ^(r4 & G1_K4)};
        else    branch_out = {^(r3 & G0_K3), ^(r3 & G1_K3)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        hamming2 = {d[1] & d[0], d[1] ^ d[0]};
    endfunction
endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state: saturating adds, ties resolve to pred0.
// Purely combinational; no flow control.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [1:0]      bm0_i,
    input  logic [1:0]      bm1_i,
    output logic [PM_W-1:0] pm_o,
    output logic            dec_o
);
    localparam int SW = PM_W + 1;

    logic [PM_W:0]   s0, s1;
    logic [PM_W-1:0] c0, c1;

    assign s0 = {1'b0, pm0_i} + SW'(bm0_i);
    assign s1 = {1'b0, pm1_i} + SW'(bm1_i);
    assign c0 = s0[PM_W] ? '1 : s0[PM_W-1:0];
    assign c1 = s1[PM_W] ? '1 : s1[PM_W-1:0];

    assign dec_o = c1 < c0;
    assign pm_o  = dec_o ? c1 : c0;
endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder, K=3/K=4; one bit out TB_DEPTH symbols after input, no backpressure.
// Optional VITERBI_ERR_COUNT_EN adds a saturating err_count of the per-symbol minimum metric increment.
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] encoded_bits,
    input  logic       choose_constraint_length,
    output logic       out_valid,
    output logic       decoded_bit
`ifdef VITERBI_ERR_COUNT_EN
    ,
    output logic [15:0] err_count
`endif
);
    localparam int                FILL_W    = $clog2(TB_DEPTH + 1);
    localparam logic [PM_W-1:0]   PM_INIT   = {1'b1, {(PM_W-1){1'b0}}};
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TB_DEPTH);

    logic [PM_W-1:0]       pm_q   [MAX_STATES];
    logic [PM_W-1:0]       pm_d   [MAX_STATES];
    logic [PM_W-1:0]       acs_pm [MAX_STATES];
    logic [TB_DEPTH-1:0]   surv_q [MAX_STATES];
    logic [TB_DEPTH-1:0]   surv_d [MAX_STATES];
    logic [MAX_STATES-1:0] acs_dec;
    logic [MAX_STATES-1:0] act;
    logic [FILL_W-1:0]     fill_q;
    logic                  mode_q, mode_set_q, upd_q, out_valid_q, decoded_q;
    logic                  k4, found;
    logic [PM_W-1:0]       min_pm;
    logic [2:0]            best;

    // The first accepted symbol decodes with the live mode input while it is being latched.
    assign k4 = mode_set_q ? mode_q : choose_constraint_length;

    for (genvar n = 0; n < MAX_STATES; n++) begin : g_state
        localparam logic [2:0] N = 3'(n);
        logic [2:0] p0, p1, win;
        logic [1:0] bm0, bm1;

        assign p0     = k4 ? {N[1:0], 1'b0} : {1'b0, N[0], 1'b0};
        assign p1     = p0 | 3'd1;
        assign bm0    = hamming2(encoded_bits, branch_out(k4, N, 1'b0));
        assign bm1    = hamming2(encoded_bits, branch_out(k4, N, 1'b1));
        assign act[n] = (n < num_states(k4));

        viterbi_acs #(.PM_W(PM_W)) u_acs (
            .pm0_i (pm_q[p0]),
            .pm1_i (pm_q[p1]),
            .bm0_i (bm0),
            .bm1_i (bm1),
            .pm_o  (acs_pm[n]),
            .dec_o (acs_dec[n])
        );

        assign win       = acs_dec[n] ? p1 : p0;
        assign surv_d[n] = act[n] ? {surv_q[win][TB_DEPTH-2:0], (k4 ? N[2] : N[1])} : surv_q[n];
    end

    always_comb begin
        min_pm = acs_pm[0];
        for (int i = 1; i < MAX_STATES; i++) begin
            if (act[i] && acs_pm[i] < min_pm) min_pm = acs_pm[i];
        end
        for (int i = 0; i < MAX_STATES; i++) begin
            pm_d[i] = act[i] ? acs_pm[i] - min_pm : pm_q[i];
        end
    end

    always_comb begin
        best  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_STATES; i++) begin
            if (!found && act[i] && pm_q[i] == '0) begin
                best  = 3'(i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_STATES; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
                surv_q[i] <= '0;
            end
            fill_q      <= '0;
            mode_q      <= 1'b0;
            mode_set_q  <= 1'b0;
            upd_q       <= 1'b0;
            out_valid_q <= 1'b0;
            decoded_q   <= 1'b0;
        end else begin
            upd_q       <= in_valid;
            out_valid_q <= upd_q && (fill_q == FILL_FULL);
            if (upd_q && (fill_q == FILL_FULL)) decoded_q <= surv_q[best][TB_DEPTH-1];
            if (in_valid) begin
                pm_q       <= pm_d;
                surv_q     <= surv_d;
                mode_q     <= k4;
                mode_set_q <= 1'b1;
                if (fill_q != FILL_FULL) fill_q <= fill_q + 1'b1;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign decoded_bit = decoded_q;

`ifdef VITERBI_ERR_COUNT_EN
    logic [15:0] err_q;
    logic [16:0] err_sum;

    assign err_sum   = {1'b0, err_q} + 17'(min_pm);
    assign err_count = err_q;

    always_ff @(posedge clk) begin
        if (rst)           err_q <= '0;
        else if (in_valid) err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
`endif
endmodule

// File: tb/tb_viterbi_decoder.sv
// Randomised bench for viterbi_decoder against a forward-trellis reference decoder with full path histories.
module tb_viterbi_decoder;
    localparam int TB     = 16;
    localparam int PM_W   = 6;
    localparam int PM_CAP = (1 << PM_W) - 1;
    localparam int MAXT   = 512;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       choose = 1'b0;
    logic [1:0] encoded_bits = 2'b00;
    logic       out_valid, decoded_bit;
`ifdef VITERBI_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    viterbi_decoder #(.TB_DEPTH(TB), .PM_W(PM_W)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .in_valid                 (in_valid),
        .encoded_bits             (encoded_bits),
        .choose_constraint_length (choose),
        .out_valid                (out_valid),
        .decoded_bit              (decoded_bit)
`ifdef VITERBI_ERR_COUNT_EN
        ,
        .err_count                (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int first_vld = -1;
    bit chk_on = 1'b0;
    bit dq[$];
    bit src[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_pm[8];
    bit m_path[8][MAXT];
    bit m_np[8][MAXT];
    int m_t, m_fill, m_err;
    bit m_k4, m_latched;
    bit pend_vld = 1'b0, pend_bit = 1'b0, exp_vld = 1'b0, exp_bit = 1'b0;
    int exp_err = 0;

    function automatic bit [1:0] enc_sym(input bit k4, input int st, input bit u);
        int kk, g0, g1, r;
        kk = k4 ? 4 : 3;
        g0 = k4 ? 15 : 7;
        g1 = k4 ? 13 : 5;
        r  = (int'(u) << (kk - 1)) | st;
        return {^(r & g0), ^(r & g1)};
    endfunction

    function automatic int next_st(input bit k4, input int st, input bit u);
        int kk;
        kk = k4 ? 4 : 3;
        return (int'(u) << (kk - 2)) | (st >> 1);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_pm[s] = (s == 0) ? 0 : (1 << (PM_W - 1));
            for (int j = 0; j < MAXT; j++) m_path[s][j] = 1'b0;
        end
        m_t = 0; m_fill = 0; m_err = 0; m_latched = 1'b0; m_k4 = 1'b0;
    endtask

    task automatic model_step(input bit [1:0] sym, input bit ch);
        int npm[8], from[8];
        int nst, kk, ns, bm, c, mn, best;
        bit [1:0] e;
        if (!m_latched) begin m_k4 = ch; m_latched = 1'b1; end
        nst = m_k4 ? 8 : 4;
        kk  = m_k4 ? 4 : 3;
        for (int s = 0; s < 8; s++) begin npm[s] = 1 << 30; from[s] = 0; end
        for (int s = 0; s < nst; s++) begin
            for (int u = 0; u < 2; u++) begin
                ns = next_st(m_k4, s, bit'(u));
                e  = enc_sym(m_k4, s, bit'(u));
                bm = int'(e[1] != sym[1]) + int'(e[0] != sym[0]);
                c  = m_pm[s] + bm;
                if (c > PM_CAP) c = PM_CAP;
                if (c < npm[ns]) begin npm[ns] = c; from[ns] = s; end
            end
        end
        mn = npm[0];
        for (int s = 1; s < nst; s++) if (npm[s] < mn) mn = npm[s];
        m_err = m_err + mn;
        if (m_err > 65535) m_err = 65535;
        for (int s = 0; s < nst; s++) begin
            for (int j = 0; j < m_t; j++) m_np[s][j] = m_path[from[s]][j];
            m_np[s][m_t] = bit'((s >> (kk - 2)) & 1);
        end
        for (int s = 0; s < nst; s++) begin
            for (int j = 0; j <= m_t; j++) m_path[s][j] = m_np[s][j];
            m_pm[s] = npm[s] - mn;
        end
        best = -1;
        for (int s = nst - 1; s >= 0; s--) if (m_pm[s] == 0) best = s;
        if (m_fill < TB) m_fill++;
        if (m_fill == TB && best >= 0) begin
            pend_vld = 1'b1;
            pend_bit = m_path[best][m_t - TB + 1];
        end else begin
            pend_vld = 1'b0;
        end
        m_t++;
    endtask

    always @(posedge clk) begin
        cyc++;
        exp_vld = pend_vld;
        exp_bit = pend_bit;
        if (rst) begin
            model_reset();
            pend_vld = 1'b0;
            exp_vld  = 1'b0;
        end else if (in_valid) begin
            model_step(encoded_bits, choose);
        end else begin
            pend_vld = 1'b0;
        end
        exp_err = m_err;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("out_valid", int'(out_valid), int'(exp_vld));
            if (exp_vld) check("decoded_bit", int'(decoded_bit), int'(exp_bit));
`ifdef VITERBI_ERR_COUNT_EN
            check("err_count", int'(err_count), exp_err);
`endif
            if (out_valid) begin
                dq.push_back(decoded_bit);
                if (first_vld < 0) first_vld = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit [1:0] s, input bit v, input bit ch);
        @(negedge clk);
        encoded_bits = s;
        in_valid     = v;
        choose       = ch;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        dq.delete();
        first_vld = -1;
    endtask

    task automatic run_stream(input bit k4, input int gap_every, input int flip_at,
                              input bit toggle, input bit rnd_gap, output int s0);
        int st;
        bit [1:0] sy;
        st = 0;
        s0 = -1;
        for (int i = 0; i < src.size(); i++) begin
            sy = enc_sym(k4, st, src[i]);
            st = next_st(k4, st, src[i]);
            if (i == flip_at) sy = sy ^ 2'b10;
            if (gap_every > 0 && (i % gap_every) == gap_every - 1) drive(2'b00, 1'b0, k4);
            if (rnd_gap && $urandom_range(0, 3) == 0) drive(2'b00, 1'b0, k4);
            drive(sy, 1'b1, (toggle && i > 0) ? bit'(i % 2) ^ k4 : k4);
            if (i == 0) s0 = cyc + 1;
        end
        repeat (TB + 4) drive(2'b00, 1'b0, k4);
    endtask

    task automatic make_src(input int nrand, input bit zero_data);
        src.delete();
        for (int i = 0; i < nrand; i++) src.push_back(zero_data ? 1'b0 : bit'($urandom_range(0, 1)));
        for (int i = 0; i < TB; i++) src.push_back(1'b0);
    endtask

    task automatic cmp_src(input string name);
        check({name, "_count"}, dq.size(), src.size() - TB + 1);
        for (int i = 0; i < dq.size() && i < src.size(); i++) check(name, int'(dq[i]), int'(src[i]));
    endtask

    task automatic load_known();
        src.delete();
        src.push_back(1'b1); src.push_back(1'b0); src.push_back(1'b1); src.push_back(1'b1);
        for (int i = 0; i < TB; i++) src.push_back(1'b0);
    endtask

    initial begin
        int s0, ones, st;
        int kenc[4];
        bit [4:0] kv;
        bit [1:0] sy;
        kenc = '{3, 2, 0, 1};
        kv   = 5'b10110;

        do_reset();
        chk_on = 1'b1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_decoded_bit", int'(decoded_bit), 0);

        // zero stream, K=3
        make_src(24, 1'b1);
        run_stream(1'b0, 0, -1, 1'b0, 1'b0, s0);
        check("zero_latency", first_vld - s0, TB);
        check("zero_count", dq.size(), 25);
        ones = 0;
        foreach (dq[i]) ones += int'(dq[i]);
        check("zero_bits", ones, 0);
`ifdef VITERBI_ERR_COUNT_EN
        check("zero_err_count", int'(err_count), 0);
`endif

        // known vector, K=3, with encoder pinned to hand-computed symbols
        do_reset();
        load_known();
        st = 0;
        for (int i = 0; i < 4; i++) begin
            sy = enc_sym(1'b0, st, src[i]);
            st = next_st(1'b0, st, src[i]);
            check("known_enc", int'(sy), kenc[i]);
        end
        run_stream(1'b0, 0, -1, 1'b0, 1'b0, s0);
        check("known_latency", first_vld - s0, TB);
        check("known_count", dq.size(), 5);
        for (int i = 0; i < 5 && i < dq.size(); i++) check("known_lit", int'(dq[i]), int'(kv[4 - i]));

        // single-bit error, K=4
        do_reset();
        make_src(64, 1'b0);
        run_stream(1'b1, 0, 20, 1'b0, 1'b0, s0);
        cmp_src("k4_err1");
`ifdef VITERBI_ERR_COUNT_EN
        check("k4_err_count", int'(err_count), 1);
`endif

        // in_valid gaps every third cycle
        do_reset();
        load_known();
        run_stream(1'b0, 3, -1, 1'b0, 1'b0, s0);
        check("gap_count", dq.size(), 5);
        for (int i = 0; i < 5 && i < dq.size(); i++) check("gap_lit", int'(dq[i]), int'(kv[4 - i]));

        // reset mid-stream with in_valid high, then a fresh stream
        do_reset();
        make_src(40, 1'b0);
        st = 0;
        for (int i = 0; i < 30; i++) begin
            sy = enc_sym(1'b0, st, src[i]);
            st = next_st(1'b0, st, src[i]);
            drive(sy, 1'b1, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; encoded_bits = 2'b11;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("midrst_out_valid", int'(out_valid), 0);
        dq.delete();
        first_vld = -1;
        make_src(24, 1'b0);
        run_stream(1'b0, 0, -1, 1'b0, 1'b0, s0);
        check("midrst_latency", first_vld - s0, TB);
        cmp_src("midrst");

        // mode input toggles after the first accepted symbol of a K=3 stream
        do_reset();
        make_src(30, 1'b0);
        run_stream(1'b0, 0, -1, 1'b1, 1'b0, s0);
        cmp_src("mode_latch");

        // random K=4 stream with random gaps and one channel error
        do_reset();
        make_src(60, 1'b0);
        run_stream(1'b1, 0, $urandom_range(10, 50), 1'b0, 1'b1, s0);
        cmp_src("k4_rand");

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
